// File: rtl/dataset_loader_pkg.sv
// rtl/dataset_loader_pkg.sv - shared dataset/SGD widths and loader state encoding
// Purpose: word/feature/address sizing and the IDLE/LOAD/DONE encoding shared with sgd_v3.
// Ports: none (package).
package dataset_loader_pkg;
    localparam int LENGTH       = 16;
    localparam int MAX_FEATURES = 15;
    localparam int ADDR_WIDTH   = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;
endpackage

// File: rtl/dataset_loader_row_ram.sv
// rtl/dataset_loader_row_ram.sv - DEPTH x DATA_WIDTH row store, one write port, registered read
// Purpose: holds committed dataset rows for the SGD engine.
// Ports: CLK/RST (RST clears only the read register), we/waddr/wdata write port,
//        raddr -> rdata one-cycle registered read (old data on same-address write).
module row_ram #(
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 256
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is never reset so a dataset survives an aborted reload.
    always_ff @(posedge CLK) begin
        if (we && ({1'b0, waddr} < DEPTH_W)) begin
            mem[waddr[IW-1:0]] <= wdata;
        end
    end

    // Out-of-range reads return zero; consumers bound addresses by data_points.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rdata <= '0;
        end else if ({1'b0, raddr} < DEPTH_W) begin
            rdata <= mem[raddr[IW-1:0]];
        end else begin
            rdata <= '0;
        end
    end
endmodule

// File: rtl/dataset_loader.sv
// rtl/dataset_loader.sv - streams Y/feature words into packed rows for the SGD engine
// Purpose: assembles in_word streams (Y then features 1..feat) into rows, commits them
//          to row_ram, and reports row count, completion and overflow.
// Ports: CLK, RST (sync active-high); start_load/feat begin a load; in_word/in_valid/
//        in_last/in_ready word stream; rd_addr -> rd_data registered row read;
//        data_points, loaded, overflow status.
module dataset_loader #(
    parameter int ADDR_WIDTH   = dataset_loader_pkg::ADDR_WIDTH,
    parameter int MAX_FEATURES = dataset_loader_pkg::MAX_FEATURES,
    parameter int LENGTH       = dataset_loader_pkg::LENGTH,
    parameter int DATA_WIDTH   = LENGTH*(MAX_FEATURES+1),
    parameter int DEPTH        = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start_load,
    input  logic [3:0]            feat,
    input  logic [LENGTH-1:0]     in_word,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] data_points,
    output logic                  loaded,
    output logic                  overflow
);
    import dataset_loader_pkg::loader_state_t;
    import dataset_loader_pkg::IDLE;
    import dataset_loader_pkg::LOAD;
    import dataset_loader_pkg::DONE;

    localparam logic [ADDR_WIDTH:0] DEPTH_W    = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] PTR_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [3:0]          MAX_FEAT_W = 4'(MAX_FEATURES);

    loader_state_t state_q, state_d;

    logic [3:0]            feat_q;
    logic [3:0]            word_cnt;
    logic [ADDR_WIDTH:0]   wr_ptr;      // one extra bit so it can reach DEPTH
    logic [ADDR_WIDTH:0]   wr_ptr_inc;
    logic [DATA_WIDTH-1:0] row_buf;
    logic [DATA_WIDTH-1:0] commit_row;
    logic [ADDR_WIDTH-1:0] data_points_q;
    logic                  overflow_q;

    logic hs, row_end, full, do_write, do_drop;

    assign hs         = in_valid && (state_q == LOAD);
    assign row_end    = hs && ((word_cnt == feat_q) || in_last);
    assign full       = (wr_ptr == DEPTH_W);
    assign do_write   = row_end && !full;
    assign do_drop    = row_end && full;
    assign wr_ptr_inc = wr_ptr + PTR_ONE;

    // row_buf is cleared after every commit, so slots never written stay zero;
    // that covers both the slots above feat_q and the padding of a truncated row.
    always_comb begin
        commit_row = row_buf;
        commit_row[DATA_WIDTH-1-LENGTH*int'(word_cnt) -: LENGTH] = in_word;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        loaded   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_load) state_d = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (do_drop || (hs && in_last)) state_d = DONE;
            end
            DONE: begin
                loaded = 1'b1;
                if (start_load) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            feat_q        <= '0;
            word_cnt      <= '0;
            wr_ptr        <= '0;
            row_buf       <= '0;
            data_points_q <= '0;
            overflow_q    <= 1'b0;
        end else if (start_load && (state_q != LOAD)) begin
            // Feature counts beyond the row's slot capacity are clamped.
            feat_q        <= (feat > MAX_FEAT_W) ? MAX_FEAT_W : feat;
            word_cnt      <= '0;
            wr_ptr        <= '0;
            row_buf       <= '0;
            data_points_q <= '0;
            overflow_q    <= 1'b0;
        end else if (hs) begin
            if (row_end) begin
                word_cnt <= '0;
                row_buf  <= '0;
                if (full) begin
                    overflow_q    <= 1'b1;
                    data_points_q <= DEPTH_W[ADDR_WIDTH-1:0];
                end else begin
                    wr_ptr        <= wr_ptr_inc;
                    data_points_q <= wr_ptr_inc[ADDR_WIDTH-1:0];
                end
            end else begin
                word_cnt <= word_cnt + 4'd1;
                row_buf  <= commit_row;
            end
        end
    end

    assign data_points = data_points_q;
    assign overflow    = overflow_q;

    row_ram #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_row_ram (
        .CLK   (CLK),
        .RST   (RST),
        .we    (do_write),
        .waddr (wr_ptr[ADDR_WIDTH-1:0]),
        .wdata (commit_row),
        .raddr (rd_addr),
        .rdata (rd_data)
    );
endmodule

// File: tb/tb_dataset_loader.sv
// tb/tb_dataset_loader.sv - self-checking bench for dataset_loader
module tb_dataset_loader;
    localparam int AW  = 12;
    localparam int MF  = 15;
    localparam int LEN = 16;
    localparam int DW  = LEN*(MF+1);
    localparam int DEP = 4;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic           start_load = 1'b0;
    logic [3:0]     feat = '0;
    logic [LEN-1:0] in_word = '0;
    logic           in_valid = 1'b0;
    logic           in_last = 1'b0;
    logic           in_ready;
    logic [AW-1:0]  rd_addr = '0;
    logic [DW-1:0]  rd_data;
    logic [AW-1:0]  data_points;
    logic           loaded;
    logic           overflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [LEN-1:0] words[$];
    logic [DW-1:0]  exp_rows[$];
    int             exp_dp;
    bit             exp_ov;
    int             exp_acc;

    always #5 CLK = ~CLK;

    dataset_loader #(
        .ADDR_WIDTH   (AW),
        .MAX_FEATURES (MF),
        .LENGTH       (LEN),
        .DATA_WIDTH   (DW),
        .DEPTH        (DEP)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start_load  (start_load),
        .feat        (feat),
        .in_word     (in_word),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .data_points (data_points),
        .loaded      (loaded),
        .overflow    (overflow)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: walk the word list as rows of (f+1) slots, Y in the top slot.
    task automatic model(input int f, input bit last_on_final);
        logic [DW-1:0] row;
        int k;
        bit lst;
        exp_rows.delete();
        exp_ov  = 1'b0;
        exp_acc = 0;
        row     = '0;
        k       = 0;
        foreach (words[i]) begin
            lst = last_on_final && (i == words.size() - 1);
            exp_acc++;
            row = row | (DW'(words[i]) << (DW - LEN*(k+1)));
            if (k == f || lst) begin
                if (exp_rows.size() == DEP) begin
                    exp_ov = 1'b1;
                    break;
                end
                exp_rows.push_back(row);
                row = '0;
                k   = 0;
            end else begin
                k++;
            end
            if (lst) break;
        end
        exp_dp = exp_ov ? DEP : exp_rows.size();
    endtask

    task automatic run_load(input int f, input bit last_on_final, input bit bp, input bit glitch);
        int acc;
        acc = 0;
        @(negedge CLK);
        feat = 4'(f);
        start_load = 1'b1;
        @(negedge CLK);
        start_load = 1'b0;
        feat = 4'($urandom);
        foreach (words[i]) begin
            if (bp) begin
                repeat ($urandom_range(0, 3)) begin
                    in_valid = 1'b0;
                    in_word  = 16'($urandom);
                    in_last  = 1'($urandom);
                    @(negedge CLK);
                end
            end
            if (!in_ready) break;
            in_valid   = 1'b1;
            in_word    = words[i];
            in_last    = last_on_final && (i == words.size() - 1);
            start_load = glitch && (i == 2);
            @(negedge CLK);
            acc++;
        end
        in_valid   = 1'b0;
        in_last    = 1'b0;
        start_load = 1'b0;
        model(f, last_on_final);
        chk("accepted_words", DW'(acc), DW'(exp_acc));
    endtask

    task automatic check_done(input string tag);
        int t;
        t = 0;
        while (!loaded && t < 50) begin
            @(negedge CLK);
            t++;
        end
        chk({tag, "_loaded"}, DW'(loaded), DW'(1));
        chk({tag, "_in_ready"}, DW'(in_ready), DW'(0));
        chk({tag, "_data_points"}, DW'(data_points), DW'(exp_dp));
        chk({tag, "_overflow"}, DW'(overflow), DW'(exp_ov));
        foreach (exp_rows[r]) begin
            rd_addr = AW'(r);
            @(negedge CLK);
            chk($sformatf("%s_row%0d", tag, r), rd_data, exp_rows[r]);
        end
    endtask

    task automatic fill_random(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back(16'($urandom));
    endtask

    initial begin
        logic [DW-1:0] row_a;
        logic [DW-1:0] row_b;
        int f;
        int nrows;

        repeat (2) @(negedge CLK);
        chk("rst_in_ready", DW'(in_ready), DW'(0));
        chk("rst_loaded", DW'(loaded), DW'(0));
        chk("rst_overflow", DW'(overflow), DW'(0));
        chk("rst_data_points", DW'(data_points), DW'(0));
        chk("rst_rd_data", rd_data, DW'(0));
        RST = 1'b0;
        @(negedge CLK);
        chk("idle_in_ready", DW'(in_ready), DW'(0));

        // Basic load with fixed words.
        words = '{16'h0800, 16'h0100, 16'h0200, 16'h0C00, 16'h0300, 16'h0400};
        run_load(2, 1'b1, 1'b0, 1'b0);
        check_done("basic");
        row_a = {16'h0800, 16'h0100, 16'h0200, 208'h0};
        row_b = {16'h0C00, 16'h0300, 16'h0400, 208'h0};
        rd_addr = '0;
        @(negedge CLK);
        chk("basic_row0_const", rd_data, row_a);
        rd_addr = AW'(1);
        @(negedge CLK);
        chk("basic_row1_const", rd_data, row_b);
        chk("basic_dp_const", DW'(data_points), DW'(2));

        // Partial final row; start_load pulse mid-load must be ignored.
        fill_random(7);
        run_load(3, 1'b1, 1'b0, 1'b1);
        check_done("partial");
        rd_addr = AW'(1);
        @(negedge CLK);
        chk("partial_row1_slot3", DW'(rd_data[DW-1-LEN*3 -: LEN]), DW'(0));

        // Overflow: feat=0, six words into a four-row store, no in_last.
        fill_random(6);
        run_load(0, 1'b0, 1'b0, 1'b0);
        check_done("overflow");
        chk("overflow_flag", DW'(overflow), DW'(1));
        chk("overflow_dp", DW'(data_points), DW'(DEP));

        // Backpressure with maximum feature count.
        fill_random(48);
        run_load(15, 1'b1, 1'b1, 1'b0);
        check_done("backpressure");

        // Random loads.
        for (int it = 0; it < 3; it++) begin
            f     = $urandom_range(0, 15);
            nrows = $urandom_range(1, 3);
            fill_random((f+1)*(nrows-1) + $urandom_range(1, f+1));
            run_load(f, 1'b1, 1'($urandom), 1'b0);
            check_done($sformatf("random%0d", it));
        end

        // Reset mid-load: row 0 complete, two words of row 1, then RST.
        fill_random(6);
        run_load(3, 1'b0, 1'b0, 1'b0);
        row_a = exp_rows[0];
        RST = 1'b1;
        rd_addr = '0;
        @(negedge CLK);
        chk("midrst_in_ready", DW'(in_ready), DW'(0));
        chk("midrst_loaded", DW'(loaded), DW'(0));
        chk("midrst_overflow", DW'(overflow), DW'(0));
        chk("midrst_data_points", DW'(data_points), DW'(0));
        chk("midrst_rd_data", rd_data, DW'(0));
        RST = 1'b0;
        @(negedge CLK);
        chk("midrst_mem_kept", rd_data, row_a);
        fill_random(4);
        run_load(1, 1'b1, 1'b0, 1'b0);
        check_done("reload");
        chk("reload_dp", DW'(data_points), DW'(2));

        // Read latency: new address appears only after the next edge, then holds.
        rd_addr = '0;
        @(negedge CLK);
        rd_addr = AW'(1);
        #1;
        chk("lat_before_edge", rd_data, exp_rows[0]);
        @(negedge CLK);
        chk("lat_after_edge", rd_data, exp_rows[1]);
        repeat (3) begin
            @(negedge CLK);
            chk("lat_hold", rd_data, exp_rows[1]);
        end
        chk("done_dp_stable", DW'(data_points), DW'(2));
        chk("done_loaded_stable", DW'(loaded), DW'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end
endmodule
